weight_stream_source: RTL and testbench

WEIGHT_STREAM_SOURCE -- requirements
Module: weight_stream_source

---
 rtl/weight_stream_pkg.sv | 20 ++
 rtl/weight_stream_rom.sv | 32 +++
 rtl/weight_stream_source.sv | 159 +++++++++++++++
 tb/tb_weight_stream_source.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/weight_stream_pkg.sv
// Shared types and constants for the weight stream source and its ROM.
package weight_stream_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Cycles from a ROM read being issued to its data being available.
  localparam int ROM_LATENCY = 2;
  // Output FIFO entries; also bounds reads outstanding plus buffered.
  localparam int FIFO_DEPTH  = 4;

  // Address width for a memory of the given depth (at least one bit).
  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/weight_stream_rom.sv
// Weight ROM with a two-stage registered read; word k reads back as the value k.
module weight_stream_rom #(
  parameter int    DATA_WIDTH = 64,
  parameter int    DEPTH      = 8,
  localparam int   ADDR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ce,
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] data
);

  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] stage1;

  assign rd_word = DATA_WIDTH'(addr);

  // Stage 1 captures the addressed word on a read; stage 2 follows one cycle later.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values and the pipeline order does not depend on statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stage1 <= '0;
      data   <= '0;
    end else begin
      if (ce) stage1 <= rd_word;
      data <= stage1;
    end
  end

endmodule

// File: rtl/weight_stream_source.sv
// Streams a ROM-resident weight tensor as valid/ready beats, REPEAT passes
// per start (or forever when CONTINUOUS), through a small output FIFO that
// absorbs the ROM read latency so the stream sustains one beat per cycle.
module weight_stream_source
  import weight_stream_pkg::*;
#(
  parameter int    PRECISION_0       = 16,
  parameter int    PRECISION_1       = 3,
  parameter int    TENSOR_SIZE_DIM_0 = 32,
  parameter int    TENSOR_SIZE_DIM_1 = 4,
  parameter int    PARALLELISM_DIM_0 = 4,
  parameter int    PARALLELISM_DIM_1 = 1,
  parameter int    REPEAT            = 1,
  parameter int    CONTINUOUS        = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  output logic [PRECISION_0-1:0] data_out [PARALLELISM_DIM_0*PARALLELISM_DIM_1],
  output logic                   data_out_valid,
  input  logic                   data_out_ready,
  output logic                   busy,
  output logic                   done
);

  localparam int ELEMS  = PARALLELISM_DIM_0 * PARALLELISM_DIM_1;
  localparam int DATA_W = PRECISION_0 * ELEMS;
  localparam int DEPTH  = (TENSOR_SIZE_DIM_0 / PARALLELISM_DIM_0) *
                          (TENSOR_SIZE_DIM_1 / PARALLELISM_DIM_1);
  localparam int ADDR_W = addr_width(DEPTH);
  localparam int PASS_W = $clog2(REPEAT) + 1;
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);

  // Fractional bits are metadata only; reject a format that cannot exist.
  if (PRECISION_1 >= PRECISION_0 ||
      TENSOR_SIZE_DIM_0 % PARALLELISM_DIM_0 != 0 ||
      TENSOR_SIZE_DIM_1 % PARALLELISM_DIM_1 != 0) begin : g_bad_params
    $error("weight_stream_source: inconsistent tensor or precision parameters");
  end

  state_t                  state, state_next;
  logic [ADDR_W-1:0]       addr;
  logic [PASS_W-1:0]       pass;
  logic [ROM_LATENCY-1:0]  rd_pipe;
  logic [CNT_W-1:0]        count;
  logic [CNT_W-1:0]        in_flight;
  logic [PTR_W-1:0]        wr_ptr, rd_ptr;
  logic [DATA_W-1:0]       fifo_mem [FIFO_DEPTH];
  logic [DATA_W-1:0]       rom_data;
  logic [DATA_W-1:0]       head_word;
  logic                    rom_ce;
  logic                    last_addr;
  logic                    last_read;
  logic                    push;
  logic                    pop;

  weight_stream_rom #(
    .DATA_WIDTH (DATA_W),
    .DEPTH      (DEPTH)
  ) u_rom (
    .clk  (clk),
    .rst  (rst),
    .ce   (rom_ce),
    .addr (addr),
    .data (rom_data)
  );

  assign in_flight = CNT_W'($countones(rd_pipe));
  assign last_addr = (addr == ADDR_W'(DEPTH - 1));
  assign last_read = last_addr && (pass == PASS_W'(REPEAT - 1)) && (CONTINUOUS == 0);
  assign push      = rd_pipe[ROM_LATENCY-1];
  assign pop       = data_out_valid && data_out_ready;

  // Next state, read issue and the done pulse.
  // NOTE: every signal driven here gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    rom_ce     = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start || CONTINUOUS != 0) state_next = RUN;
      end
      RUN: begin
        // Only issue when the read is guaranteed a FIFO slot on arrival.
        rom_ce = (count + in_flight) < CNT_W'(FIFO_DEPTH);
        if (rom_ce && last_read) state_next = DRAIN;
      end
      DRAIN: begin
        if (count == '0 && in_flight == '0) begin
          state_next = IDLE;
          done       = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Read address and pass counters; the final read of a run rewinds both.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr <= '0;
      pass <= '0;
    end else if (rom_ce) begin
      if (last_addr) begin
        addr <= '0;
        pass <= last_read ? '0 : pass + PASS_W'(1);
      end else begin
        addr <= addr + ADDR_W'(1);
      end
    end
  end

  // Track issued reads through the ROM pipeline; reset discards them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rd_pipe <= '0;
    else      rd_pipe <= {rd_pipe[ROM_LATENCY-2:0], rom_ce};
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // FIFO storage.
  // NOTE: the storage array is deliberately not reset; stale entries are never
  // visible because the output is masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= rom_data;
  end

  assign data_out_valid = (count != '0);
  assign busy           = (state != IDLE);
  assign head_word      = data_out_valid ? fifo_mem[rd_ptr] : '0;

  // Split the head word into beat elements, element 0 in the low bits.
  always_comb begin
    for (int j = 0; j < ELEMS; j++) begin
      data_out[j] = head_word[PRECISION_0*j +: PRECISION_0];
    end
  end

endmodule

// File: tb/tb_weight_stream_source.sv
// Randomized self-checking bench for weight_stream_source. The expected beat
// stream is built from the tensor description (REPEAT passes over words
// 0..DEPTH-1, ROM word k holding the value k) and compared beat by beat.
module tb_weight_stream_source;

  localparam int P0    = 16;
  localparam int D0    = 8;
  localparam int PA0   = 2;
  localparam int D1    = 2;
  localparam int PA1   = 1;
  localparam int REP   = 2;
  localparam int DEPTH = (D0 / PA0) * (D1 / PA1);
  localparam int BEATS = DEPTH * REP;

  logic          clk = 1'b0;
  logic          rst;
  logic          rst_c;
  logic          start;
  logic          ready_a;
  logic          ready_c;
  logic [P0-1:0] data_a [PA0*PA1];
  logic [P0-1:0] data_c [PA0*PA1];
  logic          valid_a, busy_a, done_a;
  logic          valid_c, busy_c, done_c;

  int checks = 0;
  int passed = 0;
  int done_pulses = 0;
  int ce_reads = 0;

  always #5 clk = ~clk;

  weight_stream_source #(
    .PRECISION_0(P0), .PRECISION_1(3),
    .TENSOR_SIZE_DIM_0(D0), .TENSOR_SIZE_DIM_1(D1),
    .PARALLELISM_DIM_0(PA0), .PARALLELISM_DIM_1(PA1),
    .REPEAT(REP), .CONTINUOUS(0)
  ) dut_a (
    .clk(clk), .rst(rst), .start(start),
    .data_out(data_a), .data_out_valid(valid_a), .data_out_ready(ready_a),
    .busy(busy_a), .done(done_a)
  );

  weight_stream_source #(
    .PRECISION_0(P0), .PRECISION_1(3),
    .TENSOR_SIZE_DIM_0(D0), .TENSOR_SIZE_DIM_1(D1),
    .PARALLELISM_DIM_0(PA0), .PARALLELISM_DIM_1(PA1),
    .REPEAT(REP), .CONTINUOUS(1)
  ) dut_c (
    .clk(clk), .rst(rst_c), .start(1'b0),
    .data_out(data_c), .data_out_valid(valid_c), .data_out_ready(ready_c),
    .busy(busy_c), .done(done_c)
  );

  // Event counters for done pulses and ROM reads issued.
  always @(negedge clk) begin
    if (done_a) done_pulses++;
    if (dut_a.rom_ce) ce_reads++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  task automatic test_reset();
    rst = 1'b0; rst_c = 1'b0; start = 1'b0; ready_a = 1'b0; ready_c = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({valid_a, busy_a, done_a, data_a[0], data_a[1]} !== '0)
      $display("FAIL reset_a: got v=%b b=%b d=%b data=%h_%h expected all 0",
               valid_a, busy_a, done_a, data_a[1], data_a[0]);
    else passed++;
    checks++;
    if ({valid_c, busy_c, done_c, data_c[0], data_c[1]} !== '0)
      $display("FAIL reset_c: got v=%b b=%b d=%b data=%h_%h expected all 0",
               valid_c, busy_c, done_c, data_c[1], data_c[0]);
    else passed++;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (busy_a !== 1'b0 || valid_a !== 1'b0)
      $display("FAIL idle_no_start: got busy=%b valid=%b expected 0 0", busy_a, valid_a);
    else passed++;
  endtask

  // mode 0: ready always 1; 1: toggling; 2: random stalls; 3: held 0 for 10 cycles.
  task automatic run_stream(input int mode, input bit restart_mid, input string name);
    logic [31:0] exp_q [$];
    logic [31:0] w, held, exp_w;
    bit pend, rdy, restarted;
    int beats, cyc, lat, d0, c0;
    for (int p = 0; p < REP; p++)
      for (int a = 0; a < DEPTH; a++) exp_q.push_back(32'(a));
    d0 = done_pulses;
    c0 = ce_reads;
    ready_a = (mode == 3) ? 1'b0 : 1'b1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    lat = 0;
    while (!valid_a && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat !== 3) $display("FAIL %s latency: got %0d edges expected 3", name, lat);
    else passed++;

    pend = 1'b0; restarted = 1'b0; held = '0; beats = 0; cyc = 0;
    while (beats < BEATS && cyc < 400) begin
      w = {data_a[1], data_a[0]};
      if (pend) begin
        checks++;
        if (valid_a !== 1'b1 || w !== held)
          $display("FAIL %s stall_hold: got v=%b data=%h expected v=1 data=%h", name, valid_a, w, held);
        else passed++;
      end
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 2 == 0);
        2:       rdy = ($urandom_range(0, 2) != 0);
        default: rdy = (cyc >= 10);
      endcase
      if (mode == 3 && cyc == 9) begin
        checks++;
        if (ce_reads - c0 !== 4)
          $display("FAIL %s reads_issued: got %0d expected 4", name, ce_reads - c0);
        else passed++;
        checks++;
        if (valid_a !== 1'b1 || w !== 32'd0)
          $display("FAIL %s held_word0: got v=%b data=%h expected v=1 data=0", name, valid_a, w);
        else passed++;
      end
      if (restart_mid && beats == 5 && !restarted) begin
        start = 1'b1;
        restarted = 1'b1;
      end else begin
        start = 1'b0;
      end
      ready_a = rdy;
      if (valid_a && rdy) begin
        checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL %s extra_beat: got data=%h expected no beat", name, w);
        end else begin
          exp_w = exp_q.pop_front();
          if (w !== exp_w)
            $display("FAIL %s beat%0d: got %h expected %h", name, beats, w, exp_w);
          else passed++;
        end
        beats++;
      end
      pend = valid_a && !rdy;
      held = w;
      cyc++;
      @(negedge clk);
    end
    start = 1'b0;
    checks++;
    if (beats !== BEATS) $display("FAIL %s beat_count: got %0d expected %0d", name, beats, BEATS);
    else passed++;
    if (mode == 0) begin
      checks++;
      if (cyc !== BEATS) $display("FAIL %s throughput: got %0d cycles expected %0d", name, cyc, BEATS);
      else passed++;
    end
    checks++;
    if (done_a !== 1'b1 || busy_a !== 1'b1)
      $display("FAIL %s done_pulse: got done=%b busy=%b expected 1 1", name, done_a, busy_a);
    else passed++;
    @(negedge clk);
    checks++;
    if (done_a !== 1'b0 || busy_a !== 1'b0 || valid_a !== 1'b0)
      $display("FAIL %s after_done: got done=%b busy=%b valid=%b expected 0 0 0",
               name, done_a, busy_a, valid_a);
    else passed++;
    repeat (6) @(negedge clk);
    checks++;
    if (done_pulses - d0 !== 1 || valid_a !== 1'b0)
      $display("FAIL %s single_done: got %0d pulses valid=%b expected 1 pulse valid=0",
               name, done_pulses - d0, valid_a);
    else passed++;
  endtask

  task automatic test_reset_midstream();
    int beats, cyc;
    ready_a = 1'b1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    beats = 0; cyc = 0;
    while (beats < 6 && cyc < 50) begin
      if (valid_a) beats++;
      cyc++;
      @(negedge clk);
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({valid_a, busy_a, done_a, data_a[0], data_a[1]} !== '0)
      $display("FAIL midreset_immediate: got v=%b b=%b d=%b data=%h_%h expected all 0",
               valid_a, busy_a, done_a, data_a[1], data_a[0]);
    else passed++;
    @(negedge clk);
    checks++;
    if ({valid_a, busy_a, done_a, data_a[0], data_a[1]} !== '0)
      $display("FAIL midreset_held: got v=%b b=%b d=%b data=%h_%h expected all 0",
               valid_a, busy_a, done_a, data_a[1], data_a[0]);
    else passed++;
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (valid_a !== 1'b0 || busy_a !== 1'b0)
      $display("FAIL midreset_no_leak: got valid=%b busy=%b expected 0 0", valid_a, busy_a);
    else passed++;
    run_stream(0, 1'b0, "after_reset");
  endtask

  task automatic test_continuous();
    int k;
    logic [31:0] w;
    ready_c = 1'b1;
    @(negedge clk); rst_c = 1'b1;
    @(negedge clk);
    checks++;
    if (busy_c !== 1'b1) $display("FAIL cont_enter_run: got busy=%b expected 1", busy_c);
    else passed++;
    k = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      w = {data_c[1], data_c[0]};
      checks++;
      if (busy_c !== 1'b1 || done_c !== 1'b0)
        $display("FAIL cont_flags cycle %0d: got busy=%b done=%b expected 1 0", cyc, busy_c, done_c);
      else passed++;
      if (valid_c) begin
        checks++;
        if (w !== 32'(k % DEPTH))
          $display("FAIL cont_beat%0d: got %h expected %h", k, w, 32'(k % DEPTH));
        else passed++;
        k++;
      end
      @(negedge clk);
    end
    checks++;
    if (k !== 37) $display("FAIL cont_beat_count: got %0d expected 37", k);
    else passed++;
  endtask

  initial begin
    test_reset();
    run_stream(0, 1'b0, "basic");
    run_stream(0, 1'b0, "back_to_back");
    run_stream(1, 1'b0, "toggle_ready");
    run_stream(2, 1'b0, "random_stall_1");
    run_stream(2, 1'b0, "random_stall_2");
    run_stream(0, 1'b1, "restart_ignored");
    test_reset_midstream();
    run_stream(3, 1'b0, "ready_hold");
    test_continuous();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
